// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM states, scan-code
// prefix bytes, the FIFO entry layout and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] data;
  } ps2_entry_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a run-length filter: the output only
// follows the synchronised input after FILT_LEN consecutive differing samples.
// Output and synchroniser reset to 1, the idle level of PS/2 lines.
module debouncer #(
  parameter int FILT_LEN = 19,
  parameter int FILT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filt
);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_filt;
  logic [FILT_W-1:0] r_cnt;

  // Synchronise the pin and count how long it has disagreed with the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= {FILT_W{1'b0}};
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        if (r_cnt == FILT_W'(FILT_LEN - 1)) begin
          r_filt <= r_sync2;
          r_cnt  <= {FILT_W{1'b0}};
        end else begin
          r_cnt <= r_cnt + {{(FILT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        r_cnt <= {FILT_W{1'b0}};
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/ps2_code_fifo.sv
// First-word fall-through FIFO for decoded scan codes. A push into a full
// FIFO is dropped and raises a sticky overflow flag unless a pop happens in
// the same cycle, in which case the push is accepted.
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [9:0] i_entry,
  input  logic       i_pop,
  output logic [9:0] o_head,
  output logic       o_valid,
  input  logic       i_ovf_clr,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == {(AW+1){1'b0}});
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage array; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_entry;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr       <= {AW{1'b0}};
      r_rd       <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd <= r_rd + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      // A new drop wins over a same-cycle clear.
      if (i_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  assign o_head     = w_empty ? 10'd0 : r_mem[r_rd];
  assign o_valid    = ~w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filters kclk/kdata, deserialises 11-bit frames,
// checks start/parity/stop, and queues accepted codes in a FIFO.
// Optional feature macro: PS2_PREFIX_DECODE_EN folds E0/F0 prefix bytes into
// the ext/brk flags of the following code instead of queueing them.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 19,
  parameter int FILT_W      = 5,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] last_code,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            w_kclk_f;
  logic            w_kd;
  logic            r_kclk_d;
  logic            w_fall;
  ps2_state_t      r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [WD_W-1:0] r_wd;
  logic            r_err_par;
  logic            r_err_frm;
  logic [7:0]      r_last_code;
  logic            r_push;
  ps2_entry_t      r_push_entry;
  ps2_entry_t      w_head;
  logic            w_stop_evt;
  logic            w_par_ok;
  logic            w_acc;
  logic            w_timeout;
  logic            w_frm_evt;
  logic            w_par_evt;
  logic            w_err;
  logic            w_is_pfx;
  logic            w_ext;
  logic            w_brk;

  debouncer #(.FILT_LEN(FILT_LEN), .FILT_W(FILT_W)) u_filt_clk (
    .clk(clk), .rst_n(rst_n), .i_raw(kclk), .o_filt(w_kclk_f)
  );

  debouncer #(.FILT_LEN(FILT_LEN), .FILT_W(FILT_W)) u_filt_data (
    .clk(clk), .rst_n(rst_n), .i_raw(kdata), .o_filt(w_kd)
  );

  // Delay the filtered clock to detect its falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kclk_d <= 1'b1;
    end else begin
      r_kclk_d <= w_kclk_f;
    end
  end

  assign w_fall     = r_kclk_d & ~w_kclk_f;
  assign w_stop_evt = (r_state == STOP) & w_fall;
  assign w_par_ok   = odd_parity9({r_par, r_shift});
  assign w_acc      = w_stop_evt & w_kd & w_par_ok;
  assign w_timeout  = (r_state != IDLE) & ~w_fall & (r_wd == WD_W'(TIMEOUT_CYC - 1));
  // A bad stop bit hides a parity error, so parity only reports with stop = 1.
  assign w_frm_evt  = (w_stop_evt & ~w_kd) | ((r_state == IDLE) & w_fall & w_kd) | w_timeout;
  assign w_par_evt  = w_stop_evt & w_kd & ~w_par_ok;
  assign w_err      = w_frm_evt | w_par_evt;

  // Frame FSM with watchdog and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      r_wd      <= {WD_W{1'b0}};
      r_err_par <= 1'b0;
      r_err_frm <= 1'b0;
    end else begin
      r_err_par <= w_par_evt;
      r_err_frm <= w_frm_evt;
      if (w_fall || r_state == IDLE) begin
        r_wd <= {WD_W{1'b0}};
      end else begin
        r_wd <= r_wd + {{(WD_W-1){1'b0}}, 1'b1};
      end
      case (r_state)
        IDLE: begin
          if (w_fall && !w_kd) begin
            r_state  <= DATA;
            r_bitcnt <= 3'd0;
          end
        end
        DATA: begin
          if (w_fall) begin
            r_shift  <= {w_kd, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (w_fall) begin
            r_par   <= w_kd;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_fall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_timeout) begin
        r_state <= IDLE;
      end
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic r_ext_pend;
  logic r_brk_pend;

  assign w_is_pfx = (r_shift == PS2_PFX_EXT) | (r_shift == PS2_PFX_BRK);
  assign w_ext    = r_ext_pend;
  assign w_brk    = r_brk_pend;

  // Remember prefixes until the next real code or any receive error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_acc) begin
      if (r_shift == PS2_PFX_EXT) begin
        r_ext_pend <= 1'b1;
      end else if (r_shift == PS2_PFX_BRK) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end else begin
      r_ext_pend <= r_ext_pend;
      r_brk_pend <= r_brk_pend;
    end
  end
`else
  assign w_is_pfx = 1'b0;
  assign w_ext    = 1'b0;
  assign w_brk    = 1'b0;
`endif

  // Register the accepted byte for the debug display and the FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_code  <= 8'd0;
      r_push       <= 1'b0;
      r_push_entry <= '{ext: 1'b0, brk: 1'b0, data: 8'd0};
    end else begin
      r_push <= w_acc & ~w_is_pfx;
      if (w_acc) begin
        r_last_code  <= r_shift;
        r_push_entry <= '{ext: w_ext, brk: w_brk, data: r_shift};
      end else begin
        r_last_code  <= r_last_code;
        r_push_entry <= r_push_entry;
      end
    end
  end

  ps2_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_push),
    .i_entry    (r_push_entry),
    .i_pop      (code_ready),
    .o_head     (w_head),
    .o_valid    (code_valid),
    .i_ovf_clr  (ovf_clr),
    .o_overflow (overflow)
  );

  assign code_data  = w_head.data;
`ifdef PS2_PREFIX_DECODE_EN
  assign code_ext   = w_head.ext;
  assign code_brk   = w_head.brk;
`else
  assign code_ext   = 1'b0;
  assign code_brk   = 1'b0;
`endif
  assign last_code  = r_last_code;
  assign err_parity = r_err_par;
  assign err_frame  = r_err_frm;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a short filter, short timeout and a
// 4-entry FIFO. Expected results are hand-computed from the frame contents.
module tb_ps2_rx_fifo;

  localparam int FL   = 4;
  localparam int FW   = 3;
  localparam int TO   = 200;
  localparam int FD   = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kclk;
  logic       kdata;
  logic [7:0] code_data;
  logic       code_ext;
  logic       code_brk;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] last_code;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;
  logic       ovf_clr;

  int n_total = 0;
  int n_bad   = 0;
  int n_par   = 0;
  int n_frm   = 0;

  ps2_rx_fifo #(.FILT_LEN(FL), .FILT_W(FW), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .code_data(code_data), .code_ext(code_ext), .code_brk(code_brk),
    .code_valid(code_valid), .code_ready(code_ready), .last_code(last_code),
    .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Count high cycles of each error pulse.
  always @(negedge clk) begin
    if (err_parity) n_par++;
    if (err_frame)  n_frm++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 kdata = f[i];
      repeat (HALF) @(posedge clk);
      #1 kclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 kclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    send_bits(mk_frame(d, bad_par, bad_stop), 11);
    @(posedge clk); #1 kdata = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, {31'd0, code_valid}, 32'd1);
    chk(tag, {22'd0, code_ext, code_brk, code_data}, {22'd0, exp});
    code_ready = 1'b1;
    @(posedge clk); #1 code_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {8'd0, code_data, code_ext, code_brk, code_valid, last_code,
              err_parity, err_frame, overflow}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int p0, f0;
    logic [10:0] f;
    kclk = 1'b1; kdata = 1'b1; code_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Frame 0x1C with exact accept / valid latency.
    f = mk_frame(8'h1C, 1'b0, 1'b0);
    send_bits(f, 10);
    @(posedge clk); #1 kdata = f[10];
    repeat (HALF) @(posedge clk);
    #1 kclk = 1'b0;
    repeat (FL + 3) @(posedge clk);
    #1 chk("lat_last_code", {24'd0, last_code}, 32'h1C);
    chk("lat_valid_early", {31'd0, code_valid}, 32'd0);
    @(posedge clk); #1 chk("lat_valid", {31'd0, code_valid}, 32'd1);
    repeat (HALF - FL - 4) @(posedge clk);
    #1 kclk = 1'b1;
    repeat (10) @(posedge clk);
    #1 pop_check("t1_head", 10'h01C);
    chk("t1_empty", {31'd0, code_valid}, 32'd0);

    // Prefix sequences.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    pop_check("pfx_brk", 10'h11C);
`else
    pop_check("raw_f0", 10'h0F0);
    pop_check("raw_1c", 10'h01C);
`endif
    chk("pfx1_empty", {31'd0, code_valid}, 32'd0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    pop_check("pfx_extbrk", 10'h375);
`else
    pop_check("raw_e0", 10'h0E0);
    pop_check("raw_f0b", 10'h0F0);
    pop_check("raw_75", 10'h075);
`endif
    chk("pfx2_empty", {31'd0, code_valid}, 32'd0);
    chk("pfx_last", {24'd0, last_code}, 32'h75);

    // Parity and framing errors.
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("par_pulse", n_par - p0, 32'd1);
    chk("par_nofrm", n_frm - f0, 32'd0);
    chk("par_nopush", {31'd0, code_valid}, 32'd0);
    chk("par_last", {24'd0, last_code}, 32'h75);
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("stop_pulse", n_frm - f0, 32'd1);
    chk("stop_nopar", n_par - p0, 32'd0);
    chk("stop_nopush", {31'd0, code_valid}, 32'd0);
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("both_frm", n_frm - f0, 32'd1);
    chk("both_nopar", n_par - p0, 32'd0);

    // Timeout after 5 data bits, then a clean 0x29.
    p0 = n_par; f0 = n_frm;
    send_bits(mk_frame(8'h29, 1'b0, 1'b0), 6);
    @(posedge clk); #1 kdata = 1'b1;
    repeat (TO + 50) @(posedge clk);
    #1 chk("to_pulse", n_frm - f0, 32'd1);
    chk("to_nopar", n_par - p0, 32'd0);
    chk("to_nopush", {31'd0, code_valid}, 32'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    pop_check("to_next", 10'h029);
    chk("to_last", {24'd0, last_code}, 32'h29);

    // Overflow with a 4-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_last", {24'd0, last_code}, 32'h05);
    for (int i = 1; i <= 4; i++) pop_check("ovf_pop", 10'(i));
    chk("ovf_empty", {31'd0, code_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Reset mid-frame with 3 entries queued.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("rst_pre_valid", {31'd0, code_valid}, 32'd1);
    send_bits(mk_frame(8'h44, 1'b0, 1'b0), 3);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst_mid_outputs");
    kclk = 1'b1; kdata = 1'b1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rst_post_empty", {31'd0, code_valid}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    pop_check("rst_next", 10'h05A);
    chk("rst_next_last", {24'd0, last_code}, 32'h5A);
    chk("rst_next_empty", {31'd0, code_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that runs entirely in the `clk` domain. It oversamples and filters the PS/2 clock and data lines, deserialises 11-bit frames, and checks odd parity, start bit and stop bit. Accepted scan codes are buffered in a FIFO with a valid/ready read port for the downstream FSM. A raw last-byte register drives the seven-segment debug display.

## Interface
- `FILT_LEN`, default 19: number of consecutive equal samples required before a filtered line changes.
- `FILT_W`, default 5: width of the filter counter; must satisfy 2^FILT_W > FILT_LEN.
- `TIMEOUT_CYC`, default 100000: number of `clk` cycles without a falling `kclk` edge that aborts a frame in progress.
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `kclk`  in  1  raw PS/2 clock from the pin.
- `kdata`  in  1  raw PS/2 data from the pin.
- `code_data`  out  8  scan code at the FIFO head.
- `code_ext`  out  1  head entry was preceded by the E0 prefix.
- `code_brk`  out  1  head entry was preceded by the F0 prefix.
- `code_valid`  out  1  FIFO not empty.
- `code_ready`  in  1  consumer pops the head when `code_valid && code_ready`.
- `last_code`  out  8  last byte received with good parity and framing (raw, including prefixes).
- `err_parity`  out  1  one-cycle pulse on a parity error.
- `err_frame`  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.
- `overflow`  out  1  sticky flag: a push was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- Input conditioning, applied to each of `kclk` and `kdata`:
  - 2-flop synchroniser, then the FILT_LEN filter.
  - Filter output resets to 1.
  - Falling edge of the filtered `kclk` produces `fall`, a 1-cycle strobe.
- Receive FSM advances only on `fall`. It samples the filtered `kdata` at that strobe.
  - IDLE: if data = 0, go to DATA with bit count = 0. If data = 1, assert `err_frame` and stay in IDLE.
  - DATA: shift the bit in LSB-first. After 8 bits, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: if stop = 1 and the parity over 9 bits is odd, accept the byte. Otherwise:
    - bad parity → pulse `err_parity`;
    - stop = 0 → pulse `err_frame`;
    - if both fail, only `err_frame` pulses.
    - Either way, return to IDLE.
- Timeout:
  - Watchdog counter clears on every `fall`.
  - In any state other than IDLE, reaching TIMEOUT_CYC pulses `err_frame`, discards the partial byte and returns to IDLE.
- On an accepted byte, `last_code` updates and the byte goes to the push logic (see Configuration).
- FIFO behaviour:
  - First-word fall-through; each entry is 10 bits (`ext`, `brk`, data).
  - Push while full is dropped and sets `overflow`. If a pop occurs in the same cycle, the push is accepted instead.
  - Pop while empty is ignored.
  - `ovf_clr` and a new overflow in the same cycle: `overflow` stays set.
- Reset (asynchronous, including mid-frame):
  - FSM → IDLE; FIFO emptied; pending prefix flags cleared.
  - All outputs 0, except the filtered lines, which are internally 1.

## Timing
- Accept: the cycle after the STOP-sample `fall`, the entry is written and `last_code` updates.
- `code_valid` rises the following cycle when the FIFO was empty, i.e. 2 cycles after the STOP `fall`.
- Error pulses are asserted on the cycle after the offending `fall` or timeout, for exactly 1 cycle.
- Input-pin-to-`fall` latency: 2 + FILT_LEN cycles.
- Pop takes effect at the clock edge. The next head is visible on the following cycle; back-to-back pops are allowed every cycle.

## Configuration
- `PS2_PREFIX_DECODE_EN` defined:
  - E0 sets `ext_pend` and F0 sets `brk_pend`; neither prefix byte is pushed.
  - The next non-prefix byte is pushed with `ext` = `ext_pend` and `brk` = `brk_pend`, then both pending flags clear.
  - A parity, frame or timeout error also clears the pending flags.
- `PS2_PREFIX_DECODE_EN` undefined:
  - Every accepted byte is pushed raw.
  - `code_ext` and `code_brk` are tied to 0; the pending flags are not built.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants `PS2_PFX_EXT` = 8'hE0 and `PS2_PFX_BRK` = 8'hF0;
  - FIFO entry struct {ext, brk, data[7:0]}.
- One sub-module, `ps2_code_fifo`: a parametrised synchronous FIFO with full/empty flags and the overflow logic.
- The input filter reuses the existing `debouncer` with FILT_LEN/FILT_W, extended with `rst_n`.

## Test plan
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → one entry {0,0,0x1C}; `last_code` = 0x1C; `code_valid` 2 cycles after the STOP `fall`.
- With `PS2_PREFIX_DECODE_EN`: frames F0,1C then E0,F0,75 → exactly 2 entries: {brk=1,0x1C} and {ext=1,brk=1,0x75}. Without the macro → 5 raw entries.
- Frame 0x1C with parity bit 1 → `err_parity` single pulse; no push; `last_code` unchanged. Stop bit 0 → `err_frame` only.
- Stall after 5 data bits for TIMEOUT_CYC+1 cycles → `err_frame` pulse, FSM back in IDLE; the following full frame 0x29 is received correctly.
- FIFO_DEPTH = 4, 5 frames 0x01..0x05 with `code_ready` = 0 → `overflow` = 1. Then 4 pops return 0x01..0x04 and `code_valid` falls. `ovf_clr` clears `overflow`.
- `rst_n` low during the DATA state with 3 entries queued → all outputs 0, FIFO empty. After release, the next frame is received normally.
